// File: rtl/mem_stage.sv
// mem_stage: LoongArch32 memory-access stage between Execute and Writeback.
//   Holds one Execute record, waits for the in-order data SRAM response of any
//   request Execute issued, extends load data and hands the finished record to
//   Writeback over a valid/allowin handshake. A flush discards the record and
//   arranges for its orphaned SRAM response to be dropped.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   flush                exception/ertn flush (priority over everything)
//   em_*                 Execute-stage record and handshake (em_valid / m_allowin)
//   data_sram_*          in-order data SRAM response
//   w_allowin, mw_*      Writeback handshake and registered record
//   md_dest/wdata/busy   forwarding to Decode and load-use stall
module mem_stage #(
    parameter int DROP_W = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        em_valid,
    output logic        m_allowin,
    input  logic [31:0] em_pc,
    input  logic [31:0] em_rf_wdata,
    input  logic [31:0] em_addr,
    input  logic        em_gr_we,
    input  logic [4:0]  em_dest,
    input  logic [3:0]  em_res_from_mem,
    input  logic        em_mem_req,
    input  logic        em_ex,
    input  logic [7:0]  em_ecode,
    input  logic        em_esubcode,
    input  logic [13:0] em_csr_addr,
    input  logic        em_csr_we,
    input  logic [31:0] em_csr_wmask,
    input  logic [31:0] em_csr_wdata,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        w_allowin,
    output logic        mw_valid,
    output logic [31:0] mw_pc,
    output logic [31:0] mw_rf_wdata,
    output logic        mw_gr_we,
    output logic [4:0]  mw_dest,
    output logic        mw_ex,
    output logic [7:0]  mw_ecode,
    output logic        mw_esubcode,
    output logic [13:0] mw_csr_addr,
    output logic        mw_csr_we,
    output logic [31:0] mw_csr_wmask,
    output logic [31:0] mw_csr_wdata,
    output logic [4:0]  md_dest,
    output logic [31:0] md_wdata,
    output logic        md_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_READY = 2'd3;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rf_wdata;
        logic [1:0]  addr_lo;
        logic        gr_we;
        logic [4:0]  dest;
        logic [3:0]  res;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } rec_t;

    logic [1:0]        state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]       rdata_buf_q, rdata_buf_d;
    rec_t              rec_q, rec_d, em_rec;

    logic        rsp, m_ready_go, drop_inc, drop_dec, is_load, sext;
    logic [31:0] src, shifted, ld_data, final_wdata;
    logic [15:0] lane_h;
    logic [7:0]  lane_b;
    logic        unused_addr_hi;

    // Only the byte offset of the address matters past Execute.
    assign unused_addr_hi = ^em_addr[31:2];

    assign em_rec = '{
        pc:        em_pc,
        rf_wdata:  em_rf_wdata,
        addr_lo:   em_addr[1:0],
        gr_we:     em_gr_we,
        dest:      em_dest,
        res:       em_res_from_mem,
        ex:        em_ex,
        ecode:     em_ecode,
        esubcode:  em_esubcode,
        csr_addr:  em_csr_addr,
        csr_we:    em_csr_we,
        csr_wmask: em_csr_wmask,
        csr_wdata: em_csr_wdata
    };

    // A response only belongs to the current record once all orphans are gone.
    assign rsp        = data_sram_data_ok & (drop_cnt_q == '0);
    assign m_ready_go = (state_q == S_READY) | (state_q == S_HOLD) | ((state_q == S_WAIT) & rsp);
    // A saturated drop counter blocks new records so no further orphan can be created.
    assign m_allowin  = (!m_valid_q | (m_ready_go & w_allowin)) & (drop_cnt_q != DROP_MAX);
    assign drop_inc   = flush & (state_q == S_WAIT) & !rsp;
    assign drop_dec   = data_sram_data_ok & (drop_cnt_q != '0);

    always_comb begin
        m_valid_d   = m_valid_q;
        state_d     = state_q;
        rec_d       = rec_q;
        rdata_buf_d = rdata_buf_q;
        drop_cnt_d  = drop_cnt_q + DROP_W'(drop_inc) - DROP_W'(drop_dec);
        if (flush) begin
            m_valid_d = 1'b0;
            state_d   = S_IDLE;
        end else if (m_allowin) begin
            m_valid_d = em_valid;
            state_d   = !em_valid ? S_IDLE : (em_mem_req & !em_ex) ? S_WAIT : S_READY;
            rec_d     = em_valid ? em_rec : rec_q;
        end else if ((state_q == S_WAIT) & rsp) begin
            // Response arrived while Writeback stalls: keep it, the bus moves on.
            state_d     = S_HOLD;
            rdata_buf_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            m_valid_q   <= 1'b0;
            drop_cnt_q  <= '0;
            rdata_buf_q <= '0;
            rec_q       <= '0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            rdata_buf_q <= rdata_buf_d;
            rec_q       <= rec_d;
        end
    end

    always_comb begin
        src         = (state_q == S_HOLD) ? rdata_buf_q : data_sram_rdata;
        shifted     = src >> {rec_q.addr_lo, 3'b000};
        lane_b      = shifted[7:0];
        lane_h      = rec_q.addr_lo[1] ? src[31:16] : src[15:0];
        sext        = ~rec_q.res[2];
        ld_data     = rec_q.res[3] ? src :
                      rec_q.res[1] ? {{16{sext & lane_h[15]}}, lane_h} :
                                     {{24{sext & lane_b[7]}}, lane_b};
        is_load     = rec_q.res[3] | rec_q.res[1] | rec_q.res[0];
        final_wdata = is_load ? ld_data : rec_q.rf_wdata;
    end

    assign mw_valid     = m_valid_q & m_ready_go & !flush;
    assign mw_pc        = rec_q.pc;
    assign mw_rf_wdata  = final_wdata;
    assign mw_gr_we     = rec_q.gr_we;
    assign mw_dest      = rec_q.dest;
    assign mw_ex        = rec_q.ex;
    assign mw_ecode     = rec_q.ecode;
    assign mw_esubcode  = rec_q.esubcode;
    assign mw_csr_addr  = rec_q.csr_addr;
    assign mw_csr_we    = rec_q.csr_we;
    assign mw_csr_wmask = rec_q.csr_wmask;
    assign mw_csr_wdata = rec_q.csr_wdata;
    assign md_dest      = rec_q.dest & {5{m_valid_q & rec_q.gr_we}};
    assign md_wdata     = final_wdata;
    assign md_busy      = m_valid_q & is_load & (state_q == S_WAIT) & !rsp;
endmodule
